// File: rtl/i2c_slave.sv
// i2c_slave: I2C target. Oversamples SCL/SDA, detects START/Sr/STOP, matches a
// 7-bit address, ACKs every write byte onto rx_*, fetches read bytes via rd_req.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN: 3-sample majority filter per line.

module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       rd_req,
    output logic       rw,
    output logic       busy,
    output logic       addressed
);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned SETTLE_CYCLES = 6;
`else
    localparam int unsigned SETTLE_CYCLES = 4;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_e;

    state_e     state_q;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_f, sda_f;
    logic       scl_prev_q, sda_prev_q;
    logic [2:0] settle_q;
    logic       ev_en, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       ack_phase_q;
    logic       sda_low_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, rd_req_q, rw_q, busy_q, addressed_q;

    // Open-drain: only ever pull low or release
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    // Two-flop synchronisers; reset to the idle (high) bus level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Majority vote over three samples rejects single-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
            scl_filt_q <= maj3(scl_hist_q);
            sda_filt_q <= maj3(sda_hist_q);
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // Previous-sample registers for edge detect; settle counter masks events
    // until the input pipeline holds real bus samples after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            settle_q   <= 3'd0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            if (!ev_en) settle_q <= settle_q + 3'd1;
        end
    end

    assign ev_en     = (settle_q == 3'(SETTLE_CYCLES));
    assign scl_rise  = ev_en &  scl_f & ~scl_prev_q;
    assign scl_fall  = ev_en & ~scl_f &  scl_prev_q;
    assign start_det = ev_en &  sda_prev_q & ~sda_f & scl_f & scl_prev_q;
    assign stop_det  = ev_en & ~sda_prev_q &  sda_f & scl_f & scl_prev_q;

    // Protocol FSM; bus conditions override every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            ack_phase_q <= 1'b0;
            sda_low_q   <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            if (stop_det) begin
                state_q     <= S_IDLE;
                sda_low_q   <= 1'b0;
                busy_q      <= 1'b0;
                addressed_q <= 1'b0;
            end else if (start_det) begin
                state_q     <= S_ADDR;
                bit_cnt_q   <= 3'd0;
                sda_low_q   <= 1'b0;
                busy_q      <= 1'b1;
                addressed_q <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: if (scl_rise) begin
                        shift_q   <= {shift_q[5:0], sda_f};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // shift_q holds the 7 address bits, sda_f is R/W
                            if (shift_q == SLAVE_ADDR && SLAVE_ADDR != 7'd0) begin
                                state_q     <= S_ADDR_ACK;
                                rw_q        <= sda_f;
                                addressed_q <= 1'b1;
                                ack_phase_q <= 1'b0;
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_low_q   <= 1'b1;
                            ack_phase_q <= 1'b1;
                        end else begin
                            sda_low_q   <= 1'b0;
                            ack_phase_q <= 1'b0;
                            if (state_q == S_WR_ACK || !rw_q) begin
                                state_q <= S_WR_DATA;
                            end else begin
                                rd_req_q <= 1'b1;
                                state_q  <= S_RD_DATA;
                            end
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        shift_q   <= {shift_q[5:0], sda_f};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q   <= {shift_q, sda_f};
                            rx_valid_q  <= 1'b1;
                            ack_phase_q <= 1'b0;
                            state_q     <= S_WR_ACK;
                        end
                    end
                    S_RD_DATA: begin
                        if (rd_req_q) begin
                            // tx_data is valid during the rd_req cycle: load and present MSB
                            shift_q   <= tx_data[6:0];
                            sda_low_q <= ~tx_data[7];
                            bit_cnt_q <= 3'd0;
                        end else if (scl_fall) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                sda_low_q <= 1'b0;
                                state_q   <= S_RD_ACK;
                            end else begin
                                sda_low_q <= ~shift_q[6];
                                shift_q   <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end
                    // Master ACK sampled on the rise; next byte fetched at the fall
                    S_RD_ACK: begin
                        if (scl_rise && sda_f) begin
                            state_q <= S_IGNORE;
                        end else if (scl_fall) begin
                            rd_req_q <= 1'b1;
                            state_q  <= S_RD_DATA;
                        end
                    end
                    S_IDLE, S_IGNORE: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rd_req    = rd_req_q;
    assign rw        = rw_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) that receives the bus driven by `i2c_master` and turns it into byte-level strobes for local target logic. It runs on its own oversampling clock and samples `i2c_scl`/`i2c_sda` through synchronisers. It detects START, repeated START and STOP, and matches a 7-bit address. It ACKs write bytes onto an `rx_*` strobe and fetches read bytes through a `rd_req` request.

## Interface
- `SLAVE_ADDR`, 7'h50: own 7-bit address.
- `clk` input 1: oversampling clock; frequency ≥ 4× SCL frequency.
- `reset` input 1: asynchronous, active-low reset.
- `i2c_scl` input 1: bus clock; never driven (no clock stretching).
- `i2c_sda` inout 1: open-drain; driven 0 or 'z, never 1.
- `rx_data` output 8: last received write byte, MSB first.
- `rx_valid` output 1: 1-cycle pulse; `rx_data` is new.
- `tx_data` input 8: read byte; captured in the `rd_req` cycle.
- `rd_req` output 1: 1-cycle pulse requesting the next read byte.
- `rw` output 1: R/W bit of the current addressed transfer.
- `busy` output 1: high from START to STOP, whether or not this target is addressed.
- `addressed` output 1: high from the address ACK until STOP or repeated START.

## Operation
- Input path: 2-flop synchroniser on SCL and SDA, then edge detect on synchronised values.
- Bit-level events:
  - `scl_rise`, `scl_fall`.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- State machine:
  - IDLE: START → ADDR, `bit_cnt`=0.
  - ADDR: shift SDA in on each `scl_rise`, 8 bits (7 address + R/W). After the 8th bit:
    - match → ADDR_ACK.
    - mismatch → IGNORE.
  - ADDR_ACK: drive SDA low from the next `scl_fall` to the following `scl_fall`. Then:
    - R/W=0 → WR_DATA.
    - R/W=1 → pulse `rd_req`, load shift register from `tx_data`, → RD_DATA.
  - WR_DATA: shift 8 bits in on `scl_rise`. On the 8th bit, update `rx_data` and pulse `rx_valid` that cycle → WR_ACK.
  - WR_ACK: drive SDA low for one SCL low/high period as in ADDR_ACK → WR_DATA. Every write byte is ACKed.
  - RD_DATA: present MSB on SDA immediately. Then shift on each `scl_fall`. A bit value of 0 drives low; 1 releases. After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample master ACK on `scl_rise`.
    - ACK (0) → pulse `rd_req`, reload, → RD_DATA.
    - NACK (1) → IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Global overrides, from any state, highest priority:
  - STOP → IDLE.
  - START → ADDR (repeated START), `bit_cnt` cleared, `addressed` cleared.
- General call (address 0) is not matched.
- `bit_cnt` is 3 bits and wraps 7→0 at each byte boundary.

## Timing
- Reset values:
  - outputs: `rx_data`=0, `rx_valid`=0, `rd_req`=0, `rw`=0, `busy`=0, `addressed`=0.
  - SDA released; state IDLE.
- Pin-to-event latency: 3 `clk` cycles without the filter, 5 with it.
- SDA drive changes occur only on the cycle after a detected `scl_fall`. The exception is the RD_DATA entry MSB, which occurs during SCL low after the ACK.
- `rx_valid` asserts 1 cycle after the `scl_rise` of the 8th data bit is detected.
- `rd_req` asserts in the cycle the ADDR_ACK or RD_ACK decision is taken. `tx_data` must be valid in that same cycle.
- `busy` rises 1 cycle after START detect and falls 1 cycle after STOP detect.
- Reset deassertion mid-transfer: the block stays in IDLE until a fresh START. Bits already on the bus are ignored.
- SDA and SCL changing in the same `clk` sample: the SDA edge counts as START/STOP only if synchronised SCL is high both before and after the edge.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined:
  - after the synchroniser, each line passes a 3-sample majority filter, adding 2 cycles of latency;
  - pulses of 1 `clk` are rejected.
- Not defined: synchronised values feed edge detection directly, and 1-cycle glitches are treated as real edges.

## Test plan
- Write to matching address: START, 0x50+W, data 0xA5, 0x3C, STOP →
  - address ACK;
  - `rx_valid` pulses twice, with `rx_data` 0xA5 then 0x3C;
  - `busy` falls after STOP.
- Address mismatch: 0x51+W, byte 0xFF →
  - SDA never driven low;
  - no `rx_valid`; `addressed`=0.
- Read with master ACK then NACK, `tx_data`=0x96 then 0x0F →
  - bus bits read 10010110, 00001111;
  - `rd_req` pulses exactly 2 times;
  - SDA released after NACK.
- Repeated START: write 0x50+W, byte 0x11, Sr, 0x50+R →
  - `rx_data`=0x11;
  - `rw` goes 0→1;
  - `rd_req` pulses after the second address ACK.
- Reset asserted during the 4th data bit, released, then a full write of 0x77 → only `rx_data`=0x77 is reported.
- With the filter enabled, a 1-cycle SDA low glitch while SCL is high → no START is detected and `busy` stays 0.
